// File: rtl/hex_decode_pkg.sv
// Shared types and constants for the seven-segment readback monitor.
// Segment constants are active-high {g,f,e,d,c,b,a} as lit on the display.
package hex_decode_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef struct packed {
    logic [3:0] nibble;
    logic       dp;
    logic       err;
  } seg_dp_t;

  // A grid sample is usable only when exactly one active-low enable is asserted.
  function automatic logic grid_legal(input logic [NUM_DIGITS-1:0] grid);
    return $countones(~grid) == 1;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational lookup from an active-low {dp,g..a} segment drive to a hex nibble.
// Unknown patterns (including blank) yield nibble 0 with err set.
module seg7_to_hex
  import hex_decode_pkg::*;
(
  input  logic [7:0] seg_i,
  output seg_dp_t    dec_o
);

  logic [6:0] lit;

  always_comb begin
    lit          = ~seg_i[6:0];
    dec_o        = '0;
    dec_o.dp     = ~seg_i[7];
    case (lit)
      SEG_0:   dec_o.nibble = 4'h0;
      SEG_1:   dec_o.nibble = 4'h1;
      SEG_2:   dec_o.nibble = 4'h2;
      SEG_3:   dec_o.nibble = 4'h3;
      SEG_4:   dec_o.nibble = 4'h4;
      SEG_5:   dec_o.nibble = 4'h5;
      SEG_6:   dec_o.nibble = 4'h6;
      SEG_7:   dec_o.nibble = 4'h7;
      SEG_8:   dec_o.nibble = 4'h8;
      SEG_9:   dec_o.nibble = 4'h9;
      SEG_A:   dec_o.nibble = 4'hA;
      SEG_B:   dec_o.nibble = 4'hB;
      SEG_C:   dec_o.nibble = 4'hC;
      SEG_D:   dec_o.nibble = 4'hD;
      SEG_E:   dec_o.nibble = 4'hE;
      SEG_F:   dec_o.nibble = 4'hF;
      default: dec_o.err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/hex_display_decoder.sv
// Passive monitor that rebuilds four hex digits from a multiplexed 7-segment drive.
// Optional HEX_DECODER_DP_EN: decode the decimal-point segment into dp_o.
module hex_display_decoder
  import hex_decode_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              hex_seg_i,
  input  logic [NUM_DIGITS-1:0]   hex_grid_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   dp_o,
  output logic                    valid_o,
  output logic                    frame_o,
  output logic                    err_o
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
`ifdef HEX_DECODER_DP_EN
  localparam logic [7:0] CMP_MASK = 8'hFF;
`else
  localparam logic [7:0] CMP_MASK = 8'h7F;
`endif

  logic [7:0]              seg_q, prev_seg_q;
  logic [NUM_DIGITS-1:0]   grid_q, prev_grid_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    captured_q, captured_d;
  logic                    capture;
  logic                    legal, same;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d, cap_sel;
  logic                    frame_done;
  logic [4*NUM_DIGITS-1:0] shadow_nib, digits_q;
  logic [NUM_DIGITS-1:0]   shadow_err;
  logic                    valid_q, frame_q, err_q;
  seg_dp_t                 dec;

  seg7_to_hex u_decode (
    .seg_i (seg_q),
    .dec_o (dec)
  );

  assign legal      = grid_legal(grid_q);
  assign same       = ((seg_q & CMP_MASK) == (prev_seg_q & CMP_MASK)) && (grid_q == prev_grid_q);
  assign frame_done = (mask_q == '1);

  // A change in seg or grid restarts the dwell and re-arms capture.
  always_comb begin
    cnt_d      = '0;
    captured_d = 1'b0;
    capture    = 1'b0;
    if (legal) begin
      if (same) begin
        cnt_d      = (cnt_q == SETTLE_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        captured_d = captured_q;
      end else begin
        cnt_d = CNT_W'(1);
      end
      if (cnt_d == SETTLE_MAX && !captured_d) begin
        capture    = 1'b1;
        captured_d = 1'b1;
      end
    end
  end

  assign cap_sel = capture ? ~grid_q : '0;
  assign mask_d  = (frame_done ? '0 : mask_q) | cap_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q       <= '1;
      grid_q      <= '1;
      prev_seg_q  <= '1;
      prev_grid_q <= '1;
      cnt_q       <= '0;
      captured_q  <= 1'b0;
      mask_q      <= '0;
      digits_q    <= '0;
      valid_q     <= 1'b0;
      frame_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      seg_q       <= hex_seg_i;
      grid_q      <= hex_grid_i;
      prev_seg_q  <= seg_q;
      prev_grid_q <= grid_q;
      cnt_q       <= cnt_d;
      captured_q  <= captured_d;
      mask_q      <= mask_d;
      frame_q     <= frame_done;
      if (frame_done) begin
        digits_q <= shadow_nib;
        err_q    <= |shadow_err;
        valid_q  <= 1'b1;
      end
    end
  end

`ifdef HEX_DECODER_DP_EN
  logic [NUM_DIGITS-1:0] shadow_dp, dp_q;
`endif

  // Shadow error bits clear on frame completion unless the same edge captures into that grid.
  genvar gi;
  for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_shadow
    logic [3:0] nib_q;
    logic       err_sh_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        nib_q    <= '0;
        err_sh_q <= 1'b0;
      end else if (cap_sel[gi]) begin
        nib_q    <= dec.nibble;
        err_sh_q <= dec.err;
      end else if (frame_done) begin
        err_sh_q <= 1'b0;
      end
    end
    assign shadow_nib[gi*4 +: 4] = nib_q;
    assign shadow_err[gi]        = err_sh_q;
`ifdef HEX_DECODER_DP_EN
    logic dp_sh_q;
    always_ff @(posedge clk) begin
      if (reset)            dp_sh_q <= 1'b0;
      else if (cap_sel[gi]) dp_sh_q <= dec.dp;
    end
    assign shadow_dp[gi] = dp_sh_q;
`endif
  end

`ifdef HEX_DECODER_DP_EN
  always_ff @(posedge clk) begin
    if (reset)           dp_q <= '0;
    else if (frame_done) dp_q <= shadow_dp;
  end
  assign dp_o = dp_q;
`else
  logic unused_dp;
  assign unused_dp = dec.dp;
  assign dp_o      = '0;
`endif

  assign digits_o = digits_q;
  assign valid_o  = valid_q;
  assign frame_o  = frame_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_hex_display_decoder.sv
// Self-checking bench: table-driven scans plus hand-written corner sequences;
// expected frames are queued at stimulus time and checked when frame_o pulses.
module tb_hex_display_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  hex_seg_i;
  logic [3:0]  hex_grid_i;
  logic [15:0] digits_o;
  logic [3:0]  dp_o;
  logic        valid_o, frame_o, err_o;

`ifdef HEX_DECODER_DP_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] seg;
    logic [3:0] nib;
    logic       err;
    logic       dp;
  } vec_t;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        err;
  } exp_t;

  vec_t tbl [20];
  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   frames = 0;
  logic prev_frame = 1'b0;

  hex_display_decoder #(.SETTLE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .hex_seg_i  (hex_seg_i),
    .hex_grid_i (hex_grid_i),
    .digits_o   (digits_o),
    .dp_o       (dp_o),
    .valid_o    (valid_o),
    .frame_o    (frame_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] gsel(input int g);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << g);
  endfunction

  task automatic show(input logic [3:0] grid, input logic [7:0] seg, input int n);
    @(negedge clk);
    hex_grid_i = grid;
    hex_seg_i  = seg;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] dp_raw, input logic e);
    exp_t x;
    x.digits = d;
    x.dp     = DP_EN ? dp_raw : 4'h0;
    x.err    = e;
    exp_q.push_back(x);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_digits"}, 32'(digits_o), 32'h0);
    check({tag, "_dp"},     32'(dp_o),     32'h0);
    check({tag, "_valid"},  32'(valid_o),  32'h0);
    check({tag, "_frame"},  32'(frame_o),  32'h0);
    check({tag, "_err"},    32'(err_o),    32'h0);
  endtask

  // Scoreboard side: every frame_o pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && frame_o) begin
      exp_t x;
      frames++;
      check("frame_not_back_to_back", 32'(prev_frame), 32'h0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame actual digits=%04h required no frame", digits_o);
      end else begin
        x = exp_q.pop_front();
        check("frame_digits", 32'(digits_o), 32'(x.digits));
        check("frame_dp",     32'(dp_o),     32'(x.dp));
        check("frame_err",    32'(err_o),    32'(x.err));
        check("frame_valid",  32'(valid_o),  32'h1);
        $display("frame %0d digits=%04h dp=%b err=%b (expected %04h %b %b)",
                 frames, digits_o, dp_o, err_o, x.digits, x.dp, x.err);
      end
    end
    prev_frame = reset ? 1'b0 : frame_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [15:0] d;
    logic [3:0]  dpv;
    logic        e;

    // Each entry: active-low seg drive and its expected decode.
    tbl[0]  = '{8'hC0, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{8'hF9, 4'h1, 1'b0, 1'b0};
    tbl[2]  = '{8'hA4, 4'h2, 1'b0, 1'b0};
    tbl[3]  = '{8'hB0, 4'h3, 1'b0, 1'b0};
    tbl[4]  = '{8'h99, 4'h4, 1'b0, 1'b0};
    tbl[5]  = '{8'h92, 4'h5, 1'b0, 1'b0};
    tbl[6]  = '{8'h82, 4'h6, 1'b0, 1'b0};
    tbl[7]  = '{8'hF8, 4'h7, 1'b0, 1'b0};
    tbl[8]  = '{8'h80, 4'h8, 1'b0, 1'b0};
    tbl[9]  = '{8'h90, 4'h9, 1'b0, 1'b0};
    tbl[10] = '{8'h88, 4'hA, 1'b0, 1'b0};
    tbl[11] = '{8'h83, 4'hB, 1'b0, 1'b0};
    tbl[12] = '{8'hC6, 4'hC, 1'b0, 1'b0};
    tbl[13] = '{8'hA1, 4'hD, 1'b0, 1'b0};
    tbl[14] = '{8'h86, 4'hE, 1'b0, 1'b0};
    tbl[15] = '{8'h8E, 4'hF, 1'b0, 1'b0};
    tbl[16] = '{8'hFF, 4'h0, 1'b1, 1'b0};
    tbl[17] = '{8'h00, 4'h8, 1'b0, 1'b1};
    tbl[18] = '{8'h40, 4'h0, 1'b0, 1'b1};
    tbl[19] = '{8'h7F, 4'h0, 1'b1, 1'b1};

    reset      = 1'b1;
    hex_seg_i  = 8'hFF;
    hex_grid_i = 4'hF;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset");

    // Basic scan A,5,0,0 with exact frame latency on the final dwell.
    show(gsel(0), 8'h88, 8);
    show(gsel(1), 8'h92, 8);
    show(gsel(2), 8'hC0, 8);
    push(16'h005A, 4'h0, 1'b0);
    @(negedge clk);
    hex_grid_i = gsel(3);
    hex_seg_i  = 8'hC0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (frame_o && lat == 0) lat = i;
    end
    check("frame_latency", 32'(lat), 32'd6);
    check("valid_sticky", 32'(valid_o), 32'h1);

    // Glitch on grid 1, and a too-short dwell on grid 3 followed by blank grid.
    show(gsel(0), 8'h88, 8);
    show(gsel(1), 8'hFF, 2);
    show(gsel(1), 8'h92, 8);
    show(gsel(2), 8'hC0, 8);
    show(gsel(3), 8'hFF, 3);
    show(4'hF,    8'hFF, 4);
    check("no_frame_short_dwell", 32'(exp_q.size() + frames), 32'd1);
    push(16'h005A, 4'h0, 1'b0);
    show(gsel(3), 8'hC0, 8);

    // Two grids enabled: no capture; mask survives, scan resumes.
    show(gsel(0), 8'hF9, 8);
    show(gsel(1), 8'hA4, 8);
    show(4'b1100, 8'hB0, 20);
    check("no_frame_multi_low", 32'(frames), 32'd2);
    show(gsel(2), 8'hB0, 8);
    push(16'h4321, 4'h0, 1'b0);
    show(gsel(3), 8'h99, 8);

    // Undecodable pattern on grid 2, then a clean frame clears err.
    show(gsel(0), 8'hB0, 8);
    show(gsel(1), 8'h99, 8);
    show(gsel(2), 8'hAA, 8);
    push(16'h7043, 4'h0, 1'b1);
    show(gsel(3), 8'hF8, 8);
    show(gsel(0), 8'hB0, 8);
    show(gsel(1), 8'h99, 8);
    show(gsel(2), 8'h92, 8);
    push(16'h7543, 4'h0, 1'b0);
    show(gsel(3), 8'hF8, 8);

    // Reset mid-frame discards grids 0-2; grid 3 alone must not complete a frame.
    show(gsel(0), 8'h80, 8);
    show(gsel(1), 8'h80, 8);
    show(gsel(2), 8'h80, 8);
    @(negedge clk);
    reset      = 1'b1;
    hex_grid_i = 4'hF;
    hex_seg_i  = 8'hFF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("midreset");
    show(gsel(3), 8'h90, 8);
    show(4'hF,    8'hFF, 4);
    check("no_frame_after_reset", 32'(valid_o), 32'h0);
    show(gsel(0), 8'hF9, 8);
    show(gsel(1), 8'hF9, 8);
    push(16'h9011, 4'h0, 1'b0);
    show(gsel(2), 8'hC0, 8);
    show(4'hF,    8'hFF, 4);

    // Decimal point only on grid 3.
    show(gsel(0), 8'hC0, 8);
    show(gsel(1), 8'hC0, 8);
    show(gsel(2), 8'hC0, 8);
    push(16'h0000, 4'b1000, 1'b0);
    show(gsel(3), 8'h40, 8);

    // Table-driven scans: four consecutive entries form one frame.
    for (int f = 0; f < 5; f++) begin
      d = '0; dpv = '0; e = 1'b0;
      for (int g = 0; g < 4; g++) begin
        d[g*4 +: 4] = tbl[f*4 + g].nib;
        dpv[g]      = tbl[f*4 + g].dp;
        e           = e | tbl[f*4 + g].err;
      end
      for (int g = 0; g < 4; g++) begin
        if (g == 3) push(d, dpv, e);
        show(gsel(g), tbl[f*4 + g].seg, 8);
      end
    end

    show(4'hF, 8'hFF, 1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check("all_frames_seen", 32'(exp_q.size()), 32'd0);
    check("frame_count", 32'(frames), 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_display_decoder.md
# hex_display_decoder

Passive monitor that reads back the multiplexed seven-segment drive produced by `processor_top` (`hex_seg_*` / `hex_grid_*`) and reconstructs the four displayed hex nibbles. It sits on the verification and in-system-debug side of the display interface, one instance per display half. Benches use it to check the displayed value in place of decoding waveforms by hand.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive identical samples required before a digit is captured. Minimum is 1.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `hex_seg_i` in 8: segment drive, active-low, ordered {dp,g,f,e,d,c,b,a}.
- `hex_grid_i` in 4: digit enables, active-low. Bit 0 is the rightmost digit.
- `digits_o` out 16: last complete frame. `[3:0]` holds grid 0 and `[15:12]` holds grid 3.
- `dp_o` out 4: decimal point per digit for the last frame.
- `valid_o` out 1: sticky. Set after the first complete frame.
- `frame_o` out 1: one-cycle pulse when `digits_o` updates.
- `err_o` out 1: the last frame contained an undecodable segment pattern.

## Operation
- Register the inputs once as `seg_q` and `grid_q`. All logic uses the registered values.
- A sample is legal only if exactly one bit of `grid_q` is 0. Any other grid pattern, including all-high or multiple-low, is illegal:
  - Clear the settle counter and the `captured` flag.
  - Leave the mask and shadows untouched.
- Settle counter:
  - If a legal sample equals the previous sample on both seg and grid, increment, saturating at `SETTLE_CYCLES`.
  - Otherwise, load 1 and clear `captured`.
- Capture happens when the counter reaches `SETTLE_CYCLES` and `captured` is 0. On capture:
  - Write the decoded nibble, dp and error bit into the shadow register for the active grid.
  - Set that grid's bit in `seen_mask`.
  - Set `captured`.
- Only one capture happens per stable dwell. If seg changes while the grid stays the same, the counter restarts and the new stable value overwrites the shadow.
- Decode (active-high abcdefg = ~`seg_q[6:0]`):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Any other pattern, including blank, decodes to nibble 0 with the error bit set.
- Frame completion happens when `seen_mask` becomes 4'hF:
  - Next cycle: `digits_o`/`dp_o` load from the shadows, `err_o` loads the OR of the shadow error bits, `frame_o`=1, `valid_o`=1.
  - Clear `seen_mask` and the shadow error bits.
- If a capture and a frame completion happen in the same cycle, the capture sets its bit in the freshly cleared mask.

## Timing
- Reset values: `digits_o`=0, `dp_o`=0, `valid_o`=0, `frame_o`=0, `err_o`=0. Mask, shadows, counter and `captured` are also cleared.
- Latency from a pin change to capture: 1 cycle of input register plus `SETTLE_CYCLES` cycles. The stable value is captured on the `SETTLE_CYCLES`-th identical registered sample.
- Latency from the final capture to `frame_o`: 1 cycle. `digits_o` changes on the same edge that `frame_o` rises.
- `frame_o` is never high on two consecutive cycles.
- Reset asserted mid-frame discards the partial frame. The first frame after reset requires all four grids to be captured again.
- Counter width is `$clog2(SETTLE_CYCLES+1)`. The counter saturates and never wraps.

## Configuration
- `HEX_DECODER_DP_EN` defined: segment bit 7 is decoded into `dp_o`. Active-low means `dp_o`=1 when bit 7 is 0.
- `HEX_DECODER_DP_EN` undefined: `dp_o` is tied to 4'h0, bit 7 is excluded from the settle comparison, and no dp shadow registers exist.

## Structure
- Package `hex_decode_pkg`:
  - `SEG_*` pattern constants for 0–F.
  - `seg_dp_t` struct {nibble, dp, err}.
  - Localparam `NUM_DIGITS`=4.
- Sub-module `seg7_to_hex`: a purely combinational lookup from active-low seg[7:0] to `seg_dp_t`.
- The top holds the input register, settle counter, shadows, mask and output registers.

## Test plan
- Scan grids 0→3 with digits A,5,0,0, each held for 8 cycles, `SETTLE_CYCLES`=4. Expect `digits_o`=16'h005A, one `frame_o` pulse, `valid_o`=1, `err_o`=0.
- Insert a 2-cycle glitch pattern (seg=8'hFF) on grid 1 between dwells. Expect no capture from the glitch and `digits_o` unchanged at 16'h005A on the next frame.
- Drive the grid with two digits enabled (4'b1100) for 20 cycles. Expect no capture and no `frame_o`; resume the scan and expect the frame to complete normally.
- Show pattern 8'hAA on grid 2 during a full scan. Expect `err_o`=1 and `digits_o`[11:8]=0; the next clean frame returns `err_o` to 0.
- Assert `reset` after grids 0–2 are captured. Expect all outputs 0, then the first `frame_o` only after all four grids are captured again.
- With `HEX_DECODER_DP_EN`, drive the dp segment low on grid 3 only. Expect `dp_o`=4'b1000; without the macro, expect `dp_o`=4'b0000.
